sirv_icb_rd_master: RTL and testbench
=====================================

Name: sirv_icb_rd_master

Overview:
- ICB initiator that reads a block of consecutive words from an ICB target (mask ROM, SRAM) and streams them out over a valid/ready port.
- Used for boot-image copy and ROM table fetch; the mirror of the ROM responder.
- Must interoperate with zero-latency responders: `rsp_valid` in the same cycle as the command, and `cmd_ready` driven combinationally from `rsp_ready`.

Parameters:
- AW, 32, ICB address width
- DW, 32, ICB data width; address step is DW/8 bytes
- CW, 16, word-count width
- FD, 4, response FIFO depth; power of 2, ≥2; also the maximum number of outstanding reads

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle pulse; begin transfer (ignored while busy)
- base_addr  input  AW  start byte address; sampled on start
- word_cnt  input  CW  number of words to read; sampled on start
- busy  output  1  transfer in progress
- done  output  1  one-cycle pulse at end of transfer
- err  output  1  sticky error flag; cleared on next accepted start
- icb_cmd_valid  output  1  command valid
- icb_cmd_ready  input  1  command ready
- icb_cmd_addr  output  AW  command byte address
- icb_cmd_read  output  1  constant 1 (read-only master)
- icb_rsp_valid  input  1  response valid
- icb_rsp_ready  output  1  response ready
- icb_rsp_err  input  1  response error
- icb_rsp_rdata  input  DW  response data
- out_valid  output  1  stream data valid
- out_ready  input  1  stream sink ready
- out_data  output  DW  stream data (FIFO head)

Behaviour:
Reset values:
- State IDLE.
- busy, done, err, icb_cmd_valid, out_valid all 0.
- icb_cmd_addr 0; all counters and FIFO pointers 0.
- icb_rsp_ready 0 during reset, 1 at all times after reset.

States: IDLE, ISSUE, DRAIN.
- IDLE:
  - start with word_cnt≠0: latch addr and remaining count, set outstanding=0, clear err, go to ISSUE.
  - start with word_cnt=0: done=1 the next cycle, no command issued, stay IDLE.
- ISSUE:
  - icb_cmd_valid = (remaining≠0) && (outstanding + fifo_count < FD). This is a credit rule: every response is guaranteed FIFO space, so rsp_ready is a constant 1.
  - icb_cmd_valid must not depend combinationally on icb_cmd_ready or any rsp signal.
  - On cmd handshake: addr += DW/8 (wraps mod 2^AW), remaining −= 1, outstanding += 1.
  - When remaining reaches 0, go to DRAIN.
- DRAIN:
  - No commands issued.
  - When outstanding=0 and FIFO empty: done=1 for one cycle, busy=0, go to IDLE.

Responses and stream:
- A response beat decrements outstanding.
- Same-cycle cmd handshake and rsp beat (zero-latency target): outstanding is unchanged net, and the FIFO push still occurs.
- rsp with err=0 pushes rdata into the FIFO.
- out_valid = FIFO non-empty. out_data is the FIFO head. Pop on out_valid && out_ready.
- Simultaneous push and pop: count unchanged, data order preserved.
- With a zero-latency target and out_ready=1, throughput is 1 word/cycle.

Error handling:
- rsp with err=1: set err sticky; data is not pushed.
- On error, remaining is forced to 0 and the state goes to DRAIN.
- Later responses still decrement outstanding, but their data is discarded.
- Words already in the FIFO are still delivered.
- done pulses after drain with err=1.

Control outputs:
- busy = (state≠IDLE). A start while busy is ignored.
- done and start never both act in the same transfer; a start in the done cycle (state IDLE) is accepted.

Reset mid-transfer:
- Immediate return to IDLE; FIFO flushed; no done pulse.
- Responses to commands issued before reset are the system's responsibility.

Test Plan:
1. Zero-latency responder (rsp_valid=cmd_valid, cmd_ready=rsp_ready), base_addr=0x100, word_cnt=4, out_ready=1 -> addresses 0x100, 0x104, 0x108, 0x10C on consecutive cycles; out_data equals ROM words 0x40–0x43 in order; done one cycle after the last pop; err=0.
2. Same transfer, word_cnt=8, out_ready=0 for 10 cycles then 1 -> at most FD=4 commands issued while stalled, none lost; all 8 words delivered in order.
3. word_cnt=0 -> no icb_cmd_valid; done=1 exactly one cycle after start; busy stays 0.
4. Responder returns err=1 on the 3rd word of word_cnt=6 -> words 1–2 delivered; no further commands; err=1; done after outstanding reaches 0.
5. Second start while busy with different base_addr -> ignored; addresses continue from the first transfer. Then rst_n low mid-transfer -> all outputs return to reset values; FIFO empty.
6. base_addr=0xFFFF_FFFC, word_cnt=2 -> second address wraps to 0x0000_0000.

Source files
------------

// File: rtl/sirv_icb_rd_master.sv
// sirv_icb_rd_master: ICB read initiator that fetches word_cnt consecutive
// words starting at base_addr and streams them out through a small FIFO.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   start, base_addr, word_cnt transfer request (sampled when idle)
//   busy, done, err            transfer status (done is a one-cycle pulse,
//                              err is sticky until the next accepted start)
//   icb_cmd_*                  ICB command channel (read-only)
//   icb_rsp_*                  ICB response channel
//   out_valid/ready/data       output word stream (out_data = FIFO head)
//
// Commands are credit-limited: outstanding reads plus buffered words never
// exceed FD, so every response has a FIFO slot and icb_rsp_ready is held at 1.
`timescale 1ns/1ps

module sirv_icb_rd_master #(
   parameter int unsigned AW = 32,
   parameter int unsigned DW = 32,
   parameter int unsigned CW = 16,
   parameter int unsigned FD = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [AW-1:0] base_addr,
   input  logic [CW-1:0] word_cnt,
   output logic          busy,
   output logic          done,
   output logic          err,
   output logic          icb_cmd_valid,
   input  logic          icb_cmd_ready,
   output logic [AW-1:0] icb_cmd_addr,
   output logic          icb_cmd_read,
   input  logic          icb_rsp_valid,
   output logic          icb_rsp_ready,
   input  logic          icb_rsp_err,
   input  logic [DW-1:0] icb_rsp_rdata,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_data
);

   localparam int unsigned PW   = $clog2(FD);
   localparam int unsigned NW   = PW + 1;
   localparam int unsigned SW   = NW + 1;
   localparam int unsigned STEP = DW / 8;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_DRAIN = 2'd2
   } state_e;

   state_e        state_q, state_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [CW-1:0] rem_q, rem_d;
   logic [NW-1:0] outst_q, outst_d;
   logic [NW-1:0] cnt_q, cnt_d;
   logic [PW-1:0] wptr_q, wptr_d;
   logic [PW-1:0] rptr_q, rptr_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          err_q, err_d;
   logic          cmd_valid_q, cmd_valid_d;
   logic          out_valid_q, out_valid_d;
   logic          rsp_ready_q;
   logic [DW-1:0] mem_q [FD];

   logic cmd_fire;
   logic rsp_fire;
   logic push;
   logic pop;

   // Handshakes; responses outside a transfer (e.g. after a reset) are ignored.
   assign cmd_fire = cmd_valid_q & icb_cmd_ready;
   assign rsp_fire = icb_rsp_valid & rsp_ready_q & (state_q != S_IDLE);
   assign push     = rsp_fire & ~icb_rsp_err & ~err_q;
   assign pop      = out_valid_q & out_ready;

   // Next-state and registered-output logic.
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      rem_d       = rem_q;
      err_d       = err_q;
      done_d      = 1'b0;
      outst_d     = outst_q + NW'(cmd_fire) - NW'(rsp_fire);
      cnt_d       = cnt_q + NW'(push) - NW'(pop);
      wptr_d      = push ? wptr_q + PW'(1) : wptr_q;
      rptr_d      = pop  ? rptr_q + PW'(1) : rptr_q;

      if (rsp_fire && icb_rsp_err) begin
         err_d = 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            if (start) begin
               err_d = 1'b0;
               if (word_cnt != '0) begin
                  addr_d  = base_addr;
                  rem_d   = word_cnt;
                  outst_d = '0;
                  state_d = S_ISSUE;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         S_ISSUE: begin
            if (cmd_fire) begin
               addr_d = addr_q + AW'(STEP);
               rem_d  = rem_q - CW'(1);
            end
            // An error response stops issuing; remaining reads are abandoned.
            if (rsp_fire && icb_rsp_err) begin
               rem_d = '0;
            end
            if (rem_d == '0) begin
               state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (outst_d == '0 && cnt_d == '0) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Output flags are evaluated on next-cycle values so they are registered
      // and never depend combinationally on the ICB handshake inputs.
      busy_d      = (state_d != S_IDLE);
      cmd_valid_d = (state_d == S_ISSUE) && (rem_d != '0) &&
                    ((SW'(outst_d) + SW'(cnt_d)) < SW'(FD));
      out_valid_d = (cnt_d != '0);
   end

   // State and control registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         addr_q      <= '0;
         rem_q       <= '0;
         outst_q     <= '0;
         cnt_q       <= '0;
         wptr_q      <= '0;
         rptr_q      <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         cmd_valid_q <= 1'b0;
         out_valid_q <= 1'b0;
         rsp_ready_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         rem_q       <= rem_d;
         outst_q     <= outst_d;
         cnt_q       <= cnt_d;
         wptr_q      <= wptr_d;
         rptr_q      <= rptr_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         err_q       <= err_d;
         cmd_valid_q <= cmd_valid_d;
         out_valid_q <= out_valid_d;
         rsp_ready_q <= 1'b1;
      end
   end

   // FIFO storage; contents are qualified by the pointers, so no reset needed.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wptr_q] <= icb_rsp_rdata;
      end
   end

   assign busy          = busy_q;
   assign done          = done_q;
   assign err           = err_q;
   assign icb_cmd_valid = cmd_valid_q;
   assign icb_cmd_addr  = addr_q;
   assign icb_cmd_read  = 1'b1;
   assign icb_rsp_ready = rsp_ready_q;
   assign out_valid     = out_valid_q;
   assign out_data      = mem_q[rptr_q];

endmodule

// File: tb/tb_sirv_icb_rd_master.sv
// Testbench for sirv_icb_rd_master against a zero-latency ROM responder whose
// word at byte address A is A>>2. Expected addresses and words are queued
// when a transfer is started and popped as the DUT issues commands / pops data.
`timescale 1ns/1ps

module tb_sirv_icb_rd_master;

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned CW = 16;
   localparam int unsigned FD = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic [AW-1:0] base_addr;
   logic [CW-1:0] word_cnt;
   logic          busy, done, err;
   logic          icb_cmd_valid, icb_cmd_ready, icb_cmd_read;
   logic [AW-1:0] icb_cmd_addr;
   logic          icb_rsp_valid, icb_rsp_ready, icb_rsp_err;
   logic [DW-1:0] icb_rsp_rdata;
   logic          out_valid, out_ready;
   logic [DW-1:0] out_data;

   logic          err_inj;
   logic [AW-1:0] err_addr;

   sirv_icb_rd_master #(.AW(AW), .DW(DW), .CW(CW), .FD(FD)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start         (start),
      .base_addr     (base_addr),
      .word_cnt      (word_cnt),
      .busy          (busy),
      .done          (done),
      .err           (err),
      .icb_cmd_valid (icb_cmd_valid),
      .icb_cmd_ready (icb_cmd_ready),
      .icb_cmd_addr  (icb_cmd_addr),
      .icb_cmd_read  (icb_cmd_read),
      .icb_rsp_valid (icb_rsp_valid),
      .icb_rsp_ready (icb_rsp_ready),
      .icb_rsp_err   (icb_rsp_err),
      .icb_rsp_rdata (icb_rsp_rdata),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_data      (out_data)
   );

   always #5 clk = ~clk;

   // Zero-latency responder: answers in the command cycle.
   assign icb_cmd_ready = icb_rsp_ready;
   assign icb_rsp_valid = icb_cmd_valid;
   assign icb_rsp_rdata = DW'(icb_cmd_addr >> 2);
   assign icb_rsp_err   = err_inj && (icb_cmd_addr == err_addr);

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [AW-1:0] exp_addr_q [$];
   logic [DW-1:0] exp_data_q [$];
   int n_cmd, n_pop, max_infl, first_cmd_cyc, last_cmd_cyc, last_pop_cyc, done_cyc;
   bit done_seen, busy_seen, mon_en;

   // Monitor on the falling edge, away from the DUT's active edge.
   always @(negedge clk) begin
      if (mon_en) begin
         if (icb_cmd_valid && icb_cmd_ready) begin
            if (n_cmd == 0) first_cmd_cyc = cyc;
            last_cmd_cyc = cyc;
            n_cmd++;
            check_eq("cmd_expected", 64'(exp_addr_q.size() != 0), 64'd1);
            if (exp_addr_q.size() != 0) check_eq("cmd_addr", 64'(icb_cmd_addr), 64'(exp_addr_q.pop_front()));
            check_eq("cmd_read", 64'(icb_cmd_read), 64'd1);
         end
         if (out_valid && out_ready) begin
            n_pop++;
            last_pop_cyc = cyc;
            check_eq("out_expected", 64'(exp_data_q.size() != 0), 64'd1);
            if (exp_data_q.size() != 0) check_eq("out_data", 64'(out_data), 64'(exp_data_q.pop_front()));
         end
         if (n_cmd - n_pop > max_infl) max_infl = n_cmd - n_pop;
         if (busy) busy_seen = 1'b1;
         if (done && !done_seen) begin
            done_seen = 1'b1;
            done_cyc  = cyc;
         end
      end
   end

   task automatic clear_sb();
      exp_addr_q.delete();
      exp_data_q.delete();
      n_cmd = 0; n_pop = 0; max_infl = 0;
      done_seen = 1'b0; busy_seen = 1'b0;
   endtask

   // Start one transfer, queue expectations, and wait (bounded) for done.
   task automatic run_xfer(input logic [AW-1:0] base, input int n, input int err_idx,
                           input int stall, output int start_cyc);
      clear_sb();
      for (int i = 0; i < n; i++) begin
         if (err_idx < 0 || i <= err_idx) exp_addr_q.push_back(AW'(base + AW'(4 * i)));
         if (err_idx < 0 || i < err_idx)  exp_data_q.push_back(DW'(AW'(base + AW'(4 * i)) >> 2));
      end
      err_inj  = (err_idx >= 0);
      err_addr = AW'(base + AW'(4 * err_idx));
      @(posedge clk); #1;
      start     = 1'b1;
      base_addr = base;
      word_cnt  = CW'(n);
      out_ready = (stall == 0);
      start_cyc = cyc;
      @(posedge clk); #1;
      start = 1'b0;
      for (int k = 0; k < 400 && !done_seen; k++) begin
         if (k + 1 >= stall) out_ready = 1'b1;
         @(posedge clk); #1;
      end
      check_eq("done_seen", 64'(done_seen), 64'd1);
      check_eq("done_pulse_width", 64'(done), 64'd0);
      check_eq("busy_after_done", 64'(busy), 64'd0);
      check_eq("addr_q_empty", 64'(exp_addr_q.size()), 64'd0);
      check_eq("data_q_empty", 64'(exp_data_q.size()), 64'd0);
      check_eq("err_flag", 64'(err), 64'(err_idx >= 0));
      err_inj = 1'b0;
   endtask

   int sc;

   initial begin
      rst_n = 1'b0; start = 1'b0; base_addr = '0; word_cnt = '0;
      out_ready = 1'b0; err_inj = 1'b0; err_addr = '0; mon_en = 1'b0;
      clear_sb();

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_busy", 64'(busy), 64'd0);
      check_eq("rst_done", 64'(done), 64'd0);
      check_eq("rst_err", 64'(err), 64'd0);
      check_eq("rst_cmd_valid", 64'(icb_cmd_valid), 64'd0);
      check_eq("rst_out_valid", 64'(out_valid), 64'd0);
      check_eq("rst_cmd_addr", 64'(icb_cmd_addr), 64'd0);
      check_eq("rst_rsp_ready", 64'(icb_rsp_ready), 64'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check_eq("rsp_ready_after_rst", 64'(icb_rsp_ready), 64'd1);
      mon_en = 1'b1;

      // 1: four words, full throughput
      run_xfer(32'h100, 4, -1, 0, sc);
      check_eq("t1_cmds", 64'(n_cmd), 64'd4);
      check_eq("t1_back_to_back", 64'(last_cmd_cyc - first_cmd_cyc), 64'd3);
      check_eq("t1_done_after_pop", 64'(done_cyc), 64'(last_pop_cyc + 1));

      // 2: eight words with sink stalled; credit limit caps in-flight at FD
      run_xfer(32'h100, 8, -1, 10, sc);
      check_eq("t2_cmds", 64'(n_cmd), 64'd8);
      check_eq("t2_pops", 64'(n_pop), 64'd8);
      check_eq("t2_max_inflight", 64'(max_infl), 64'(FD));

      // 3: zero-length transfer
      run_xfer(32'h100, 0, -1, 0, sc);
      check_eq("t3_cmds", 64'(n_cmd), 64'd0);
      check_eq("t3_done_latency", 64'(done_cyc), 64'(sc + 1));
      check_eq("t3_never_busy", 64'(busy_seen), 64'd0);

      // 4: error on the third word
      run_xfer(32'h300, 6, 2, 0, sc);
      check_eq("t4_cmds", 64'(n_cmd), 64'd3);
      check_eq("t4_pops", 64'(n_pop), 64'd2);

      // 5: second start while busy is ignored, then reset mid-transfer
      clear_sb();
      for (int i = 0; i < 8; i++) exp_addr_q.push_back(AW'(32'h200 + 4 * i));
      @(posedge clk); #1;
      start = 1'b1; base_addr = 32'h200; word_cnt = CW'(8); out_ready = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      start = 1'b1; base_addr = 32'h800; word_cnt = CW'(3);
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check_eq("t5_busy", 64'(busy), 64'd1);
      check_eq("t5_cmds_stalled", 64'(n_cmd), 64'(FD));
      rst_n = 1'b0;
      #1;
      check_eq("t5_rst_busy", 64'(busy), 64'd0);
      check_eq("t5_rst_cmd_valid", 64'(icb_cmd_valid), 64'd0);
      check_eq("t5_rst_out_valid", 64'(out_valid), 64'd0);
      check_eq("t5_rst_cmd_addr", 64'(icb_cmd_addr), 64'd0);
      check_eq("t5_rst_rsp_ready", 64'(icb_rsp_ready), 64'd0);
      check_eq("t5_rst_done", 64'(done), 64'd0);
      @(posedge clk); #3;
      rst_n = 1'b1;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_eq("t5_post_out_valid", 64'(out_valid), 64'd0);
      check_eq("t5_post_rsp_ready", 64'(icb_rsp_ready), 64'd1);
      check_eq("t5_post_busy", 64'(busy), 64'd0);
      check_eq("t5_no_done", 64'(done_seen), 64'd0);
      check_eq("t5_no_pops", 64'(n_pop), 64'd0);

      // 6: address wrap
      run_xfer(32'hFFFF_FFFC, 2, -1, 0, sc);
      check_eq("t6_cmds", 64'(n_cmd), 64'd2);
      check_eq("t6_pops", 64'(n_pop), 64'd2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
